seg_p2s: RTL and testbench

SEG_P2S -- requirements
Module: seg_p2s

---
 rtl/seg_p2s.sv | 133 +++++++++++++
 tb/tb_seg_p2s.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_p2s.sv
// seg_p2s: serialises four hex digits to an external seven-segment shift-register chain.
// Each digit becomes one active-low byte {dp,g,f,e,d,c,b,a}. The 32-bit frame is shifted
// out MSB first on seg_clk, and then seg_pen strobes the chain's output latches.
module seg_p2s #(
    parameter int HALF = 1                 // system-clock cycles per seg_clk phase, >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] num,
    input  logic [3:0]  point,
    input  logic [3:0]  le,
    output logic        busy,
    output logic        done,
    output logic        seg_clk,
    output logic        seg_sout,
    output logic        seg_pen,
    output logic        seg_clrn
);

    localparam int PW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(HALF - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_t;

    state_t        state;
    logic [31:0]   frame;
    logic [4:0]    bitcnt;
    logic [PW-1:0] phase;
    logic [31:0]   frame_in;

    // Active-low segment pattern for one hex digit, before the point and blank overrides.
    function automatic logic [7:0] hex_code(input logic [3:0] d);
        logic [7:0] c;
        unique case (d)
            4'h0: c = 8'hC0;
            4'h1: c = 8'hF9;
            4'h2: c = 8'hA4;
            4'h3: c = 8'hB0;
            4'h4: c = 8'h99;
            4'h5: c = 8'h92;
            4'h6: c = 8'h82;
            4'h7: c = 8'hF8;
            4'h8: c = 8'h80;
            4'h9: c = 8'h90;
            4'hA: c = 8'h88;
            4'hB: c = 8'h83;
            4'hC: c = 8'hC6;
            4'hD: c = 8'hA1;
            4'hE: c = 8'h86;
            default: c = 8'h8E;
        endcase
        return c;
    endfunction

    // Build the frame from the live inputs; blanking overrides the decimal point.
    always_comb begin
        frame_in = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = hex_code(num[4*i +: 4]);
            if (point[i]) b[7] = 1'b0;
            if (le[i])    b    = 8'hFF;
            frame_in[8*i +: 8] = b;
        end
    end

    // Frame FSM: capture, shift 32 bits at 2*HALF cycles each, then a one-cycle latch strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            seg_clk  <= 1'b0;
            seg_sout <= 1'b0;
            seg_pen  <= 1'b0;
            seg_clrn <= 1'b0;
            bitcnt   <= '0;
            phase    <= '0;
            frame    <= '0;
        end else begin
            seg_clrn <= 1'b1;
            done     <= 1'b0;
            seg_pen  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        frame    <= frame_in;
                        // First bit must already be valid during the first low phase.
                        seg_sout <= frame_in[31];
                        busy     <= 1'b1;
                        bitcnt   <= '0;
                        phase    <= '0;
                        seg_clk  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + 1'b1;
                    end else begin
                        phase <= '0;
                        if (!seg_clk) begin
                            seg_clk <= 1'b1;
                        end else begin
                            seg_clk <= 1'b0;
                            if (bitcnt == 5'd31) begin
                                seg_pen <= 1'b1;
                                done    <= 1'b1;
                                state   <= LATCH;
                            end else begin
                                bitcnt   <= bitcnt + 5'd1;
                                frame    <= {frame[30:0], 1'b0};
                                seg_sout <= frame[30];
                            end
                        end
                    end
                end
                LATCH: begin
                    busy     <= 1'b0;
                    seg_sout <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_p2s.sv
// tb_seg_p2s: directed and random frames on HALF=1 and HALF=3 instances, checked against a
// digit-table reference model and a cycle-counting observer of the serial interface.
module tb_seg_p2s;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, start3;
    logic [15:0] num;
    logic [3:0]  point, le;
    logic busy1, done1, sclk1, sout1, pen1, clrn1;
    logic busy3, done3, sclk3, sout3, pen3, clrn3;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_p2s #(.HALF(1)) u1 (
        .clk(clk), .rst(rst), .start(start1), .num(num), .point(point), .le(le),
        .busy(busy1), .done(done1), .seg_clk(sclk1), .seg_sout(sout1), .seg_pen(pen1),
        .seg_clrn(clrn1)
    );

    seg_p2s #(.HALF(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .num(num), .point(point), .le(le),
        .busy(busy3), .done(done3), .seg_clk(sclk3), .seg_sout(sout3), .seg_pen(pen3),
        .seg_clrn(clrn3)
    );

    function automatic logic [31:0] ref_frame(input logic [15:0] n, input logic [3:0] p,
                                              input logic [3:0] l);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = hex_tab[n[4*i +: 4]];
            if (p[i]) b[7] = 1'b0;
            if (l[i]) b = 8'hFF;
            f[8*i +: 8] = b;
        end
        return f;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input int h, input logic v);
        if (h == 1) start1 = v;
        else        start3 = v;
    endtask

    task automatic smp(input int h, output logic b, output logic d, output logic ck,
                       output logic so, output logic pe);
        if (h == 1) begin b = busy1; d = done1; ck = sclk1; so = sout1; pe = pen1; end
        else        begin b = busy3; d = done3; ck = sclk3; so = sout3; pe = pen3; end
    endtask

    // Pulse start, then watch one whole frame: bits at seg_clk rising edges, phase lengths,
    // busy length, done/seg_pen timing. restart_at>0 re-pulses start with a new num mid-frame.
    task automatic run_frame(input int h, input logic [31:0] exp, input string tag,
                             input int restart_at);
        logic [31:0] got;
        int rises, busy_n, done_n, done_at, pen_n, pen_bad, ph_err, run, c;
        logic prev_ck, b, d, ck, so, pe;
        bit seen, fin;
        got = '0; rises = 0; busy_n = 0; done_n = 0; done_at = 0; pen_n = 0; pen_bad = 0;
        ph_err = 0; run = 0; prev_ck = 1'b0; seen = 0; fin = 0;
        set_start(h, 1'b1);
        @(negedge clk);
        set_start(h, 1'b0);
        c = 1;
        while (!fin && c <= 64*h + 20) begin
            smp(h, b, d, ck, so, pe);
            if (b) busy_n++;
            if (d) begin done_n++; done_at = c; end
            if (pe) begin pen_n++; if (!d || ck) pen_bad++; end
            if (ck !== prev_ck) begin
                if (run != h) ph_err++;
                run = 1;
                if (ck) begin
                    if (rises < 32) got = {got[30:0], so};
                    rises++;
                end
            end else begin
                run++;
            end
            prev_ck = ck;
            if (restart_at > 0 && rises == restart_at && ck && run == 1) begin
                set_start(h, 1'b1);
                num = ~num;
            end else begin
                set_start(h, 1'b0);
            end
            if (b) seen = 1;
            else if (seen) fin = 1;
            c++;
            @(negedge clk);
        end
        chk({tag, " frame bits"}, got, exp);
        chk({tag, " rising edges"}, 32'(rises), 32'd32);
        chk({tag, " done count"}, 32'(done_n), 32'd1);
        chk({tag, " done cycle"}, 32'(done_at), 32'(64*h + 1));
        chk({tag, " busy cycles"}, 32'(busy_n), 32'(64*h + 1));
        chk({tag, " pen count"}, 32'(pen_n), 32'd1);
        chk({tag, " pen timing"}, 32'(pen_bad), 32'd0);
        chk({tag, " phase errors"}, 32'(ph_err), 32'd0);
        chk({tag, " frame ended"}, 32'(fin), 32'd1);
    endtask

    initial begin
        int dn, idle_runs, idle_bad, low;
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; num = '0; point = '0; le = '0;
        repeat (2) @(negedge clk);
        chk("rst busy1", 32'(busy1), 32'd0);
        chk("rst done1", 32'(done1), 32'd0);
        chk("rst sclk1", 32'(sclk1), 32'd0);
        chk("rst sout1", 32'(sout1), 32'd0);
        chk("rst pen1", 32'(pen1), 32'd0);
        chk("rst clrn1", 32'(clrn1), 32'd0);
        chk("rst busy3", 32'(busy3), 32'd0);
        chk("rst clrn3", 32'(clrn3), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("clrn1 after rst", 32'(clrn1), 32'd1);
        chk("clrn3 after rst", 32'(clrn3), 32'd1);

        num = 16'h5703; point = 4'b0000; le = 4'b0000;
        run_frame(1, 32'h92F8C0B0, "h1 5703", 0);

        num = 16'h0123; point = 4'b0101; le = 4'b1000;
        run_frame(1, 32'hFF79A430, "h1 points/blank", 0);

        num = 16'h1234; point = 4'b0000; le = 4'b0000;
        run_frame(1, 32'hF9A4B099, "h1 restart ignored", 10);
        repeat (2) @(negedge clk);
        chk("no queued frame", 32'(busy1), 32'd0);

        // Reset while bit 20 is being shifted; start held with rst must be ignored.
        num = 16'hABCD; point = 4'b0010; le = 4'b0000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid-shift busy", 32'(busy1), 32'd1);
        rst = 1'b1; start1 = 1'b1;
        @(negedge clk);
        chk("abort clrn", 32'(clrn1), 32'd0);
        chk("abort busy", 32'(busy1), 32'd0);
        chk("abort done", 32'(done1), 32'd0);
        chk("abort pen", 32'(pen1), 32'd0);
        chk("abort sclk", 32'(sclk1), 32'd0);
        rst = 1'b0; start1 = 1'b0;
        @(negedge clk);
        chk("abort clrn back", 32'(clrn1), 32'd1);
        chk("start with rst ignored", 32'(busy1), 32'd0);
        run_frame(1, ref_frame(num, point, le), "h1 after abort", 0);

        // Continuous start: frames separated by exactly one idle cycle.
        num = 16'h9E6F; point = 4'b1001; le = 4'b0100;
        dn = 0; idle_runs = 0; idle_bad = 0; low = 0;
        start1 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 198; i++) begin
            if (busy1) begin
                if (low > 0) begin idle_runs++; if (low != 1) idle_bad++; end
                low = 0;
            end else begin
                low++;
            end
            if (done1) dn++;
            if (i == 197) start1 = 1'b0;
            @(negedge clk);
        end
        chk("held start done count", 32'(dn), 32'd3);
        chk("held start idle gaps", 32'(idle_runs), 32'd2);
        chk("held start gap length", 32'(idle_bad), 32'd0);
        chk("held start stops", 32'(busy1), 32'd0);

        num = 16'hFFFF; point = 4'b0000; le = 4'b0000;
        run_frame(3, 32'h8E8E8E8E, "h3 FFFF", 0);

        for (int k = 0; k < 6; k++) begin
            num = 16'($urandom); point = 4'($urandom); le = 4'($urandom_range(0, 15));
            run_frame(1, ref_frame(num, point, le), $sformatf("h1 rand%0d", k), 0);
        end
        for (int k = 0; k < 3; k++) begin
            num = 16'($urandom); point = 4'($urandom); le = 4'($urandom_range(0, 15));
            run_frame(3, ref_frame(num, point, le), $sformatf("h3 rand%0d", k), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
